ex_div_ctrl: RTL
================

Name: ex_div_ctrl

Overview:
- Iterative radix-2 divider and sequencer attached beside the EX stage. Executes RV32M DIV/DIVU/REM/REMU over multiple cycles.
- Holds the pipeline through a stall request while running, then hands back a 32-bit result and its destination register address for EX to forward to MEM.
- Accepts pipeline flush (annul) at any point.

Parameters:
- WIDTH, 32, operand/result width; iteration counter width is clog2(WIDTH).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  EX presents a divide op this cycle
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- opv1  in  WIDTH  dividend
- opv2  in  WIDTH  divisor
- reg_waddr_i  in  5  destination register of the op
- annul  in  1  flush; abandon current op
- stall_req  out  1  hold IF/ID/EX this cycle
- done  out  1  result valid, one-cycle pulse
- result  out  WIDTH  quotient or remainder
- reg_waddr_o  out  5  destination captured at start

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - result, reg_waddr_o, done and all internal registers are 0.
  - stall_req is forced 0.
- States: IDLE, CHECK, RUN, DONE.
- stall_req (combinational) = (IDLE & start & ~annul) | CHECK | RUN. It is 0 in DONE so EX advances in the same cycle that done=1.
- IDLE:
  - On start & ~annul, capture op, opv1, opv2 and reg_waddr_i, then go to CHECK.
  - start in any other state is ignored; EX holds it because stall_req=1.
- CHECK, one cycle:
  - Divisor==0: result = all-ones for DIV/DIVU, dividend for REM/REMU; go to DONE.
  - Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0; go to DONE.
  - Otherwise: load |dividend| and |divisor| (signed ops only; unsigned ops use raw values), record neg_q = sign(a)^sign(b) and neg_r = sign(a), clear the remainder accumulator and counter, go to RUN.
- RUN:
  - One restoring shift-subtract step per cycle, MSB first.
  - The counter runs 0..WIDTH-1; after the step with counter==WIDTH-1, go to DONE.
- DONE:
  - Register the result: quotient or remainder per op, negated if neg_q or neg_r respectively for signed ops.
  - done=1 for exactly this cycle; next state is IDLE.
  - result and reg_waddr_o hold their values until the next DONE.
- Latency (start sampled at edge T):
  - Normal: done high in cycle T+WIDTH+2, i.e. T+34.
  - Special case: done high in cycle T+2.
- annul:
  - In CHECK, RUN or DONE: next state is IDLE, done stays 0 (annul in DONE suppresses the pulse), result is unchanged.
  - In IDLE: annul together with start → start is ignored.
- Back-to-back ops: a start in the cycle after DONE (state IDLE) is accepted normally. There is no bubble beyond the DONE cycle.
- rst mid-operation: immediate return to IDLE with all outputs 0. No residual done pulse.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: CHECK additionally tests |dividend| < |divisor| (after the special cases).
  - If true: quotient 0, remainder = original dividend, go straight to DONE. Latency is T+2.
- Undefined: every non-special op takes the full WIDTH RUN cycles. Latency is T+34.

Test Plan:
- DIVU 100/7 at T → stall_req high T..T+33, done=1 at T+34, result=14, reg_waddr_o=captured addr. Repeat as REMU → result=2.
- DIV 0xFFFFFFF9(-7)/2 → result=0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIV 7/0xFFFFFFFE → 0xFFFFFFFD.
- DIVU 5/0 → done at T+2, result=0xFFFFFFFF. REM 5/0 → result=5.
- DIV 0x80000000/0xFFFFFFFF → done at T+2, result=0x80000000. REM → 0.
- Start DIVU, assert annul at RUN cycle 10 → IDLE next cycle, stall_req=0, no done, result keeps prior value. A new start then completes correctly.
- Assert rst asynchronously mid-RUN → result=0, done=0, stall_req=0 before the next clk edge. With DIV_EARLY_OUT_EN defined, DIVU 3/10 → done at T+2, result=0; REMU 3/10 → 3.

Source files
------------

// File: rtl/ex_div_ctrl_if.sv
// Handshake bundle between the EX stage (master) and the iterative divider (slave).
interface ex_div_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] opv1;
   logic [WIDTH-1:0] opv2;
   logic [4:0]       reg_waddr_i;
   logic             annul;
   logic             stall_req;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [4:0]       reg_waddr_o;

   modport master (
      output start, op, opv1, opv2, reg_waddr_i, annul,
      input  stall_req, done, result, reg_waddr_o
   );

   modport slave (
      input  start, op, opv1, opv2, reg_waddr_i, annul,
      output stall_req, done, result, reg_waddr_o
   );
endinterface

// File: rtl/ex_div_ctrl.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU beside EX.
// Optional macro DIV_EARLY_OUT_EN: finish in CHECK when |dividend| < |divisor|.
module ex_div_ctrl #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   ex_div_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic [4:0]       waddr_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dsr_q;
   logic             neg_quo;
   logic             neg_rem;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] result_q;
   logic [4:0]       waddr_out_q;

   logic             is_signed;
   logic             is_rem;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             div_zero;
   logic             overflow;
   logic             early_out;
   logic             special;
   logic [WIDTH:0]   trial;
   logic             last_step;
   logic [WIDTH-1:0] final_val;
   logic             done_int;

   assign is_signed = ~op_q[0];
   assign is_rem    = op_q[1];
   assign abs_a     = (is_signed && dividend_q[WIDTH-1]) ? -dividend_q : dividend_q;
   assign abs_b     = (is_signed && divisor_q[WIDTH-1])  ? -divisor_q  : divisor_q;
   assign div_zero  = (divisor_q == '0);
   assign overflow  = is_signed && (dividend_q == {1'b1, {(WIDTH-1){1'b0}}})
                      && (divisor_q == '1);
`ifdef DIV_EARLY_OUT_EN
   assign early_out = (abs_a < abs_b);
`else
   assign early_out = 1'b0;
`endif
   assign special   = div_zero | overflow | early_out;
   // Partial remainder never exceeds 2*divisor, so one extra bit is enough for the trial subtract.
   assign trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
   assign last_step = (cnt == CW'(WIDTH-1));
   assign final_val = is_rem ? (neg_rem ? -rem_q : rem_q)
                             : (neg_quo ? -quo_q : quo_q);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (bus.start && !bus.annul) state_next = CHECK;
         CHECK: begin
            if (bus.annul)    state_next = IDLE;
            else if (special) state_next = DONE;
            else              state_next = RUN;
         end
         RUN: begin
            if (bus.annul)      state_next = IDLE;
            else if (last_step) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs; the result is shown combinationally in DONE so it lines up with the done pulse.
   always_comb begin
      done_int        = (state == DONE) && !bus.annul;
      bus.done        = done_int;
      bus.stall_req   = !rst && (((state == IDLE) && bus.start && !bus.annul)
                                 || (state == CHECK) || (state == RUN));
      bus.result      = done_int ? final_val : result_q;
      bus.reg_waddr_o = done_int ? waddr_q : waddr_out_q;
   end

   // Datapath: capture, special-case resolution, shift-subtract steps, result hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         waddr_q     <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dsr_q       <= '0;
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
         cnt         <= '0;
         result_q    <= '0;
         waddr_out_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.annul) begin
                  op_q       <= bus.op;
                  dividend_q <= bus.opv1;
                  divisor_q  <= bus.opv2;
                  waddr_q    <= bus.reg_waddr_i;
               end
            end
            CHECK: begin
               cnt     <= '0;
               neg_quo <= 1'b0;
               neg_rem <= 1'b0;
               if (div_zero) begin
                  quo_q <= '1;
                  rem_q <= dividend_q;
               end else if (overflow) begin
                  quo_q <= {1'b1, {(WIDTH-1){1'b0}}};
                  rem_q <= '0;
`ifdef DIV_EARLY_OUT_EN
               end else if (early_out) begin
                  quo_q <= '0;
                  rem_q <= dividend_q;
`endif
               end else begin
                  quo_q   <= abs_a;
                  rem_q   <= '0;
                  dsr_q   <= abs_b;
                  neg_quo <= is_signed && (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
                  neg_rem <= is_signed && dividend_q[WIDTH-1];
               end
            end
            RUN: begin
               if (!trial[WIDTH]) begin
                  rem_q <= trial[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               if (!bus.annul) begin
                  result_q    <= final_val;
                  waddr_out_q <= waddr_q;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
